// File: rtl/pool_seq_ctrl_if.sv
// pool_seq_ctrl_if
// Bundles the control handshake and the two buffer ports of the pooling
// sequencer so they travel as one port.
//
// Signals:
//   start, abort      host -> sequencer  pass control
//   busy, done        sequencer -> host  pass status (done is a 1-cycle pulse)
//   rd_en, rd_addr    sequencer -> input buffer
//   rd_data           input buffer -> sequencer (valid 1 cycle after rd_en)
//   wr_en, wr_addr,
//   wr_data           sequencer -> output buffer
//   wr_ready          output buffer -> sequencer (accepts when high with wr_en)
//
// Modports:
//   master  host/buffer side
//   slave   sequencer side
interface pool_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output start, abort, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, abort, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl
// Sequencer for 1-D max pooling over a column-major feature map. For every
// output element (ocol, ch) it reads KERNEL_WIDTH taps from the input buffer,
// keeps the signed maximum, and writes it to the output buffer, honouring
// write backpressure. Channels are the inner loop, output columns the outer.
//
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    pool_seq_ctrl_if.slave: start/abort/busy/done, input-buffer read
//          port (rd_en/rd_addr/rd_data) and output-buffer write port
//          (wr_en/wr_addr/wr_data/wr_ready)
module pool_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_COLS     = 16,
  parameter int NUM_CHANNELS = 32,
  parameter int KERNEL_WIDTH = 2,
  parameter int STRIDE       = 2,
  parameter int ADDR_WIDTH   = 10
) (
  input logic            clk,
  input logic            rst_n,
  pool_seq_ctrl_if.slave bus
);

  localparam int OUT_COLS = (NUM_COLS - KERNEL_WIDTH) / STRIDE + 1;

  // Loop bounds and factors in address width so all address math stays
  // in one width and wraps naturally.
  localparam logic [ADDR_WIDTH-1:0] LAST_OCOL = ADDR_WIDTH'(OUT_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CH   = ADDR_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(KERNEL_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A  = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] NCH_A     = ADDR_WIDTH'(NUM_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ocol, ch, tap;
  logic [DATA_WIDTH-1:0] acc;
  logic                  rd_pending;
  logic                  rd_first;
  logic                  last_elem;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] rd_addr_calc;
  logic [ADDR_WIDTH-1:0] wr_addr_calc;

  assign last_elem    = (ocol == LAST_OCOL) && (ch == LAST_CH);
  assign wr_accept    = bus.wr_ready && !bus.abort;
  assign rd_addr_calc = (ocol * STRIDE_A + tap) * NCH_A + ch;
  assign wr_addr_calc = ocol * NCH_A + ch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort beats a write accept in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = READ;
      end
      READ: begin
        if (bus.abort)            state_d = IDLE;
        else if (tap == LAST_TAP) state_d = LAST;
      end
      LAST: begin
        if (bus.abort) state_d = IDLE;
        else           state_d = WRITE;
      end
      WRITE: begin
        if (bus.abort)         state_d = IDLE;
        else if (bus.wr_ready) state_d = last_elem ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears them without waiting for a clock edge. Addresses are
  // forced to zero outside the state that uses them.
  always_comb begin
    bus.busy    = (state_q == READ) || (state_q == LAST) || (state_q == WRITE);
    bus.done    = (state_q == DONE);
    bus.rd_en   = (state_q == READ);
    bus.rd_addr = (state_q == READ) ? rd_addr_calc : '0;
    bus.wr_en   = (state_q == WRITE);
    bus.wr_addr = (state_q == WRITE) ? wr_addr_calc : '0;
    bus.wr_data = acc;
  end

  // Loop counters: tap steps inside READ; ch/ocol advance only on an
  // accepted write, and do not advance past the final element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocol <= '0;
      ch   <= '0;
      tap  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            ocol <= '0;
            ch   <= '0;
            tap  <= '0;
          end
        end
        READ: begin
          if (!bus.abort && tap != LAST_TAP) tap <= tap + ONE;
        end
        WRITE: begin
          if (wr_accept && !last_elem) begin
            tap <= '0;
            if (ch == LAST_CH) begin
              ch   <= '0;
              ocol <= ocol + ONE;
            end else begin
              ch <= ch + ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read data arrives one cycle after rd_en, so remember whether a read was
  // issued last cycle and whether it was tap 0 (which loads unconditionally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      rd_first   <= 1'b0;
    end else begin
      rd_pending <= (state_q == READ);
      rd_first   <= (state_q == READ) && (tap == '0);
    end
  end

  // Signed running maximum; later taps replace it only when strictly greater.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (rd_pending) begin
      if (rd_first || ($signed(bus.rd_data) > $signed(acc))) acc <= bus.rd_data;
    end
  end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// tb_pool_seq_ctrl
// Directed bench for pool_seq_ctrl. Instance dut1 uses the default geometry
// (K=2, S=2); dut2 uses K=3, S=1. Both read from one behavioural input
// buffer holding col*100+ch, and a posedge monitor logs accepted writes.
module tb_pool_seq_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pool_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  pool_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  pool_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_COLS(16), .NUM_CHANNELS(32),
    .KERNEL_WIDTH(2), .STRIDE(2), .ADDR_WIDTH(AW)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  pool_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_COLS(16), .NUM_CHANNELS(32),
    .KERNEL_WIDTH(3), .STRIDE(1), .ADDR_WIDTH(AW)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  logic [DW-1:0] mem [0:1023];

  int vectors     = 0;
  int miscompares = 0;

  int wr_cnt1     = 0;
  int wr_cnt2     = 0;
  int done_cnt1   = 0;
  int done_cnt2   = 0;
  int overlap_cnt = 0;
  int max_rd2     = 0;
  logic [AW-1:0] log_addr1 [0:2047];
  logic [DW-1:0] log_data1 [0:2047];
  logic [AW-1:0] log_addr2 [0:511];
  logic [DW-1:0] log_data2 [0:511];

  // Input buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (bus1.rd_en) bus1.rd_data <= mem[bus1.rd_addr];
    if (bus2.rd_en) bus2.rd_data <= mem[bus2.rd_addr];
  end

  // Write/done monitor. An abort in the same cycle wins over the accept.
  always @(posedge clk) begin
    if (bus1.wr_en && bus1.wr_ready && !bus1.abort) begin
      if (wr_cnt1 < 2048) begin
        log_addr1[wr_cnt1] <= bus1.wr_addr;
        log_data1[wr_cnt1] <= bus1.wr_data;
      end
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (bus2.wr_en && bus2.wr_ready && !bus2.abort) begin
      if (wr_cnt2 < 512) begin
        log_addr2[wr_cnt2] <= bus2.wr_addr;
        log_data2[wr_cnt2] <= bus2.wr_data;
      end
      wr_cnt2 <= wr_cnt2 + 1;
    end
    if (bus1.done) done_cnt1 <= done_cnt1 + 1;
    if (bus2.done) done_cnt2 <= done_cnt2 + 1;
    if ((bus1.rd_en && bus1.wr_en) || (bus2.rd_en && bus2.wr_en)) overlap_cnt <= overlap_cnt + 1;
    if (bus2.rd_en && int'(bus2.rd_addr) > max_rd2) max_rd2 <= int'(bus2.rd_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits for the next falling edge, then drives start/abort of dut1.
  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    bus1.start = s;
    bus1.abort = a;
  endtask

  // Runs one dut1 pass from the current falling edge (dut1 must be idle).
  // mode 0 plain, 1 stray start mid-pass, 2 stall element 3 for 5 cycles,
  // 3 abort in WRITE of element 10, 4 assert reset in READ of element 50.
  // Returns cycle indices of first rd_en and of done (-1 if not seen).
  task automatic runPass(input int mode, input int budget,
                         output int t_rd, output int t_done);
    int  cyc;
    bit  stalled;
    cyc     = 0;
    t_rd    = -1;
    t_done  = -1;
    stalled = 1'b0;
    bus1.start = 1'b1;
    while (cyc < budget && t_done < 0) begin
      @(negedge clk);
      cyc++;
      bus1.start = (mode == 1 && cyc == 100);
      if (bus1.rd_en && t_rd < 0) t_rd = cyc;
      if (bus1.done) t_done = cyc;
      if (mode == 2 && !stalled && bus1.wr_en && bus1.wr_addr == 10'd3) begin
        stalled = 1'b1;
        bus1.wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          checkOutput("bp_wr_en", bus1.wr_en, 1);
          checkOutput("bp_wr_addr", bus1.wr_addr, 3);
          checkOutput("bp_wr_data", bus1.wr_data, 103);
          checkOutput("bp_rd_en", bus1.rd_en, 0);
          @(negedge clk);
          cyc++;
        end
        checkOutput("bp_wr_en_after", bus1.wr_en, 1);
        bus1.wr_ready = 1'b1;
      end
      if (mode == 3 && bus1.wr_en && bus1.wr_addr == 10'd10) begin
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        return;
      end
      if (mode == 4 && bus1.rd_en && bus1.rd_addr == 10'd82) begin
        rst_n = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int t_rd, t_done, base, dbase, errs, bad, cyc, hits;

    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.wr_ready = 1'b1;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.wr_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = (i < 512) ? 16'((i / 32) * 100 + (i % 32)) : 16'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus1.busy, 0);
    checkOutput("rst_done", bus1.done, 0);
    checkOutput("rst_rd_en", bus1.rd_en, 0);
    checkOutput("rst_wr_en", bus1.wr_en, 0);
    checkOutput("rst_rd_addr", bus1.rd_addr, 0);
    checkOutput("rst_wr_addr", bus1.wr_addr, 0);
    checkOutput("rst_wr_data", bus1.wr_data, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_busy", bus1.busy, 0);

    // Pass 1 with a stray start while busy.
    base = wr_cnt1; dbase = done_cnt1;
    runPass(1, 3000, t_rd, t_done);
    checkOutput("p1_done_seen", t_done >= 0, 1);
    checkOutput("p1_latency", t_done - t_rd, 1024);
    checkOutput("p1_busy_in_done", bus1.busy, 0);
    bus1.start = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("p1_done_width", bus1.done, 0);
    checkOutput("p1_start_in_done_ignored", bus1.busy, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("p1_no_queued_start", bus1.busy, 0);
    checkOutput("p1_writes", wr_cnt1 - base, 256);
    checkOutput("p1_done_pulses", done_cnt1 - dbase, 1);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (log_addr1[base+i] !== 10'(i)) errs++;
      if (log_data1[base+i] !== 16'((2 * (i / 32) + 1) * 100 + (i % 32))) errs++;
    end
    checkOutput("p1_order_data", errs, 0);
    checkOutput("p1_first_data", log_data1[base], 100);
    checkOutput("p1_last_data", log_data1[base+255], 1531);

    // Signed compare: ch0 (-2,-32768), ch1 (-2,5), ch2 (-256,-128).
    mem[0] = 16'hFFFE; mem[32] = 16'h8000;
    mem[1] = 16'hFFFE; mem[33] = 16'h0005;
    mem[2] = 16'hFF00; mem[34] = 16'hFF80;
    base = wr_cnt1;
    runPass(0, 3000, t_rd, t_done);
    checkOutput("sgn1_done_seen", t_done >= 0, 1);
    checkOutput("sgn1_ch0", log_data1[base], 16'hFFFE);
    checkOutput("sgn1_ch1", log_data1[base+1], 16'h0005);
    checkOutput("sgn1_ch2", log_data1[base+2], 16'hFF80);
    applyStimulus(1'b0, 1'b0);
    mem[0] = 16'h8000; mem[32] = 16'hFFFE;
    base = wr_cnt1;
    runPass(0, 3000, t_rd, t_done);
    checkOutput("sgn2_ch0", log_data1[base], 16'hFFFE);
    mem[0] = 16'd0; mem[32] = 16'd100;
    mem[1] = 16'd1; mem[33] = 16'd101;
    mem[2] = 16'd2; mem[34] = 16'd102;
    applyStimulus(1'b0, 1'b0);

    // Backpressure on element 3.
    base = wr_cnt1;
    runPass(2, 3000, t_rd, t_done);
    checkOutput("bp_done_seen", t_done >= 0, 1);
    checkOutput("bp_latency", t_done - t_rd, 1029);
    checkOutput("bp_writes", wr_cnt1 - base, 256);
    hits = 0;
    for (int i = 0; i < 256; i++) if (log_addr1[base+i] == 10'd3) hits++;
    checkOutput("bp_single_write", hits, 1);
    applyStimulus(1'b0, 1'b0);

    // Abort in WRITE of element 10.
    base = wr_cnt1; dbase = done_cnt1;
    runPass(3, 3000, t_rd, t_done);
    checkOutput("ab_busy", bus1.busy, 0);
    checkOutput("ab_wr_en", bus1.wr_en, 0);
    checkOutput("ab_rd_en", bus1.rd_en, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (bus1.busy || bus1.rd_en || bus1.wr_en || bus1.done) bad++;
    end
    checkOutput("ab_stays_idle", bad, 0);
    checkOutput("ab_writes", wr_cnt1 - base, 10);
    checkOutput("ab_no_done", done_cnt1 - dbase, 0);
    base = wr_cnt1;
    runPass(0, 3000, t_rd, t_done);
    checkOutput("ab_rerun_latency", t_done - t_rd, 1024);
    checkOutput("ab_rerun_writes", wr_cnt1 - base, 256);
    applyStimulus(1'b0, 1'b0);

    // Reset during READ of element 50.
    base = wr_cnt1; dbase = done_cnt1;
    runPass(4, 3000, t_rd, t_done);
    #1;
    checkOutput("mr_busy", bus1.busy, 0);
    checkOutput("mr_rd_en", bus1.rd_en, 0);
    checkOutput("mr_rd_addr", bus1.rd_addr, 0);
    checkOutput("mr_wr_en", bus1.wr_en, 0);
    checkOutput("mr_wr_addr", bus1.wr_addr, 0);
    checkOutput("mr_wr_data", bus1.wr_data, 0);
    checkOutput("mr_done", bus1.done, 0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (bus1.busy || bus1.rd_en) bad++;
    end
    checkOutput("mr_waits_idle", bad, 0);
    checkOutput("mr_writes", wr_cnt1 - base, 50);
    checkOutput("mr_no_done", done_cnt1 - dbase, 0);

    // K=3, S=1 instance: 14 output columns, 448 writes.
    base = wr_cnt2; dbase = done_cnt2;
    @(negedge clk);
    bus2.start = 1'b1;
    cyc = 0; t_rd = -1; t_done = -1;
    while (cyc < 5000 && t_done < 0) begin
      @(negedge clk);
      cyc++;
      bus2.start = 1'b0;
      if (bus2.rd_en && t_rd < 0) t_rd = cyc;
      if (bus2.done) t_done = cyc;
    end
    @(negedge clk);
    checkOutput("k3_done_seen", t_done >= 0, 1);
    checkOutput("k3_latency", t_done - t_rd, 2240);
    checkOutput("k3_writes", wr_cnt2 - base, 448);
    checkOutput("k3_done_pulses", done_cnt2 - dbase, 1);
    errs = 0;
    for (int i = 0; i < 448; i++) begin
      if (log_addr2[base+i] !== 10'(i)) errs++;
      if (log_data2[base+i] !== 16'(((i / 32) + 2) * 100 + (i % 32))) errs++;
    end
    checkOutput("k3_order_data", errs, 0);
    checkOutput("k3_first_data", log_data2[base], 200);
    checkOutput("k3_last_data", log_data2[base+447], 1531);
    checkOutput("k3_max_rd_addr", max_rd2, 511);

    checkOutput("rd_wr_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pool_seq_ctrl.md
POOL_SEQ_CTRL -- requirements
Module: pool_seq_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, 16, sample width (signed two's complement); NUM_COLS, 16, input feature-map columns; NUM_CHANNELS, 32, channels per column; KERNEL_WIDTH, 2, pooling window width (>=1); STRIDE, 2, window step (>=1); ADDR_WIDTH, 10, buffer address width.
REQ-002 Derived: OUT_COLS = (NUM_COLS-KERNEL_WIDTH)/STRIDE + 1 (integer division); NUM_OUT = OUT_COLS*NUM_CHANNELS.
REQ-003 Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one pooling pass
- abort  in  1  cancel current pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse, pass completed
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  ADDR_WIDTH  input-buffer address
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  output-buffer write request
- wr_addr  out  ADDR_WIDTH  output-buffer address
- wr_data  out  DATA_WIDTH  pooled maximum
- wr_ready  in  1  output buffer accepts write when high with wr_en
REQ-004 Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.

Function
REQ-005 Input layout: element (col, ch) at rd_addr = col*NUM_CHANNELS + ch; output element (ocol, ch) at wr_addr = ocol*NUM_CHANNELS + ch.
REQ-006 Element order: ch inner (0..NUM_CHANNELS-1), ocol outer (0..OUT_COLS-1).
REQ-007 FSM states: IDLE, READ, LAST, WRITE, DONE.
REQ-008 IDLE: busy=0; start=1 -> READ with ocol=0, ch=0, tap n=0; otherwise stay.
REQ-009 READ: rd_en=1, rd_addr=((ocol*STRIDE)+n)*NUM_CHANNELS+ch; one tap per cycle, n=0..KERNEL_WIDTH-1; after tap KERNEL_WIDTH-1 -> LAST.
REQ-010 Accumulator: in the cycle after each read, rd_data is compared signed; tap 0 loads the accumulator unconditionally, later taps replace it only if strictly greater.
REQ-011 LAST: rd_en=0; captures final tap; -> WRITE.
REQ-012 WRITE: wr_en=1, wr_addr per REQ-005, wr_data=accumulator; wr_en, wr_addr, wr_data held stable until wr_ready=1 sampled with wr_en=1.
REQ-013 On write accept: if last element (ocol=OUT_COLS-1, ch=NUM_CHANNELS-1) -> DONE, else advance ch (wrapping to 0 and incrementing ocol) and -> READ with n=0.
REQ-014 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-015 Latency: with wr_ready tied high each element takes KERNEL_WIDTH+2 cycles; pass takes NUM_OUT*(KERNEL_WIDTH+2) cycles from first READ cycle to DONE cycle.
REQ-016 busy=1 in READ, LAST, WRITE; 0 in IDLE and DONE.
REQ-017 start while busy=1 or in DONE is ignored; no queuing.
REQ-018 abort=1 in READ, LAST or WRITE -> IDLE at next edge; no further rd_en/wr_en; done not asserted; abort in IDLE/DONE ignored; abort has priority over write accept in same cycle.
REQ-019 rd_en and wr_en never high in the same cycle; rd_en=0 outside READ; wr_en=0 outside WRITE.
REQ-020 Columns beyond (OUT_COLS-1)*STRIDE+KERNEL_WIDTH-1 are never read.

Reset
REQ-021 rst_n=0 immediately forces IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data, accumulator, counters = 0.
REQ-022 Reset mid-pass discards progress; after release, block waits in IDLE for a new start.

Verification
REQ-023 Defaults, wr_ready=1, buffer value(col,ch)=col*100+ch, start pulse -> 256 writes, wr_addr 0..255 in order, wr_data(ocol,ch)=(2*ocol+1)*100+ch, done one pulse exactly 1024 cycles after first rd_en.
REQ-024 Signed compare: col0 ch0 = 16'hFFFE (-2), col1 ch0 = 16'h8000 -> first write wr_data=16'hFFFE; swap values -> still 16'hFFFE.
REQ-025 Backpressure: wr_ready low 5 cycles at element 3 -> wr_en/wr_addr=3/wr_data stable those 5 cycles, no rd_en, single write accepted; total pass length +5 cycles.
REQ-026 abort asserted in WRITE of element 10 -> IDLE next cycle, exactly 10 writes total, done never pulses; subsequent start runs full 256-write pass.
REQ-027 rst_n low during READ of element 50 -> all outputs 0 asynchronously; start during busy ignored (no restart, write count unchanged); KERNEL_WIDTH=3, STRIDE=1 -> OUT_COLS=14, 448 writes, max over three consecutive columns.
